mem_port_arbiter: RTL

- Shares the single external memory port between I-cache refills and D-cache refills/write-backs.
- Sits below both caches. The fetch stage stalls (memory_stall) while its I-cache miss waits here.
- Fixed D-cache priority with an anti-starvation counter, so fetch cannot be locked out by long D-side traffic.
- One transaction in flight; memory outputs are registered and held until the memory acknowledges.

---
 rtl/mem_arb_pkg.sv | 14 +
 rtl/mem_port_arbiter_if.sv | 38 +++
 rtl/mem_port_arbiter.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory-port arbiter and the caches above it.
package mem_arb_pkg;

    localparam int ADDR_W = 28;   // block address (128-bit lines)
    localparam int DATA_W = 128;  // one cache line

    typedef enum logic [1:0] {
        IDLE,
        SERVE_I,
        SERVE_D,
        DONE
    } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Cache-side and memory-side signals of the shared memory port.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = mem_arb_pkg::ADDR_W,
    parameter int DATA_W = mem_arb_pkg::DATA_W
);

    logic              i_read;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_rdata;
    logic              i_ready;

    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ready;

    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    // Arbiter view.
    modport slave (
        input  i_read, i_addr, d_read, d_write, d_addr, d_wdata, mem_rdata, mem_ready,
        output i_rdata, i_ready, d_rdata, d_ready, mem_read, mem_write, mem_addr, mem_wdata
    );

    // Environment view: the two caches plus the memory.
    modport master (
        output i_read, i_addr, d_read, d_write, d_addr, d_wdata, mem_rdata, mem_ready,
        input  i_rdata, i_ready, d_rdata, d_ready, mem_read, mem_write, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between I-cache refills and D-cache refills/write-backs:
// fixed D priority, anti-starvation counter for I, one transaction in flight.
module mem_port_arbiter #(
    parameter int ADDR_W     = mem_arb_pkg::ADDR_W,
    parameter int DATA_W     = mem_arb_pkg::DATA_W,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus
);

    import mem_arb_pkg::*;

    localparam int              CNT_W      = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    arb_state_e state_q, state_d;
    logic       d_req, grant_i, grant_d, serving;

    logic              mem_read_q,  mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] i_rdata_q,   i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q,   d_rdata_d;
    logic              i_ready_q,   i_ready_d;
    logic              d_ready_q,   d_ready_d;
    logic [CNT_W-1:0]  starve_cnt,  starve_d;

    assign d_req   = bus.d_read | bus.d_write;
    assign serving = (state_q == SERVE_I) || (state_q == SERVE_D);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of process evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        grant_i = 1'b0;
        grant_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.i_read && (starve_cnt == STARVE_LIM || !d_req)) begin
                    grant_i = 1'b1;
                    state_d = SERVE_I;
                end else if (d_req) begin
                    grant_d = 1'b1;
                    state_d = SERVE_D;
                end
            end
            SERVE_I, SERVE_D: if (bus.mem_ready) state_d = DONE;
            DONE:             state_d = IDLE;
            default:          state_d = IDLE;
        endcase
    end

    // Next values of the registered memory/cache outputs and the starvation counter.
    always_comb begin
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        i_ready_d   = 1'b0;
        d_ready_d   = 1'b0;
        starve_d    = starve_cnt;

        if (grant_i) begin
            mem_read_d  = 1'b1;
            mem_write_d = 1'b0;
            mem_addr_d  = bus.i_addr;
            starve_d    = '0;
        end else if (grant_d) begin
            mem_addr_d = bus.d_addr;
            // A write-back beats a refill so a dirty line reaches memory before it is re-read.
            if (bus.d_write) begin
                mem_read_d  = 1'b0;
                mem_write_d = 1'b1;
                mem_wdata_d = bus.d_wdata;
            end else begin
                mem_read_d  = 1'b1;
                mem_write_d = 1'b0;
            end
            if (!bus.i_read)                 starve_d = '0;
            else if (starve_cnt != STARVE_LIM) starve_d = starve_cnt + CNT_W'(1);
        end

        if (serving && bus.mem_ready) begin
            mem_read_d  = 1'b0;
            mem_write_d = 1'b0;
            if (state_q == SERVE_I) begin
                i_rdata_d = bus.mem_rdata;
                i_ready_d = 1'b1;
            end else begin
                d_rdata_d = bus.mem_rdata;
                d_ready_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            i_ready_q   <= 1'b0;
            d_ready_q   <= 1'b0;
            starve_cnt  <= '0;
        end else begin
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
            i_ready_q   <= i_ready_d;
            d_ready_q   <= d_ready_d;
            starve_cnt  <= starve_d;
        end
    end

    assign bus.mem_read  = mem_read_q;
    assign bus.mem_write = mem_write_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.i_rdata   = i_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.i_ready   = i_ready_q;
    assign bus.d_ready   = d_ready_q;

endmodule
